// File: rtl/branch_predictor.sv
// Bimodal branch predictor: a table of 2-bit saturating counters indexed by
// PC word address. The prediction is read combinationally and the table
// trains on resolved branches.
module branch_predictor #(
    parameter int unsigned K = 13
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_in,
    input  logic        update_en,
    input  logic [31:0] update_pc,
    input  logic        actual_taken,
    output logic        prediction
);

    localparam int unsigned Depth = 2 ** K;

    // Counter encoding: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T.
    logic [1:0]   pht [Depth];
    logic [K-1:0] pred_idx;
    logic [K-1:0] upd_idx;
    logic [1:0]   upd_cur;
    logic [1:0]   upd_next;

    // Bits [1:0] are the byte offset of an aligned instruction.
    assign pred_idx = pc_in[K+1:2];
    assign upd_idx  = update_pc[K+1:2];
    assign upd_cur  = pht[upd_idx];

    // No bypass: a same-cycle update becomes visible only after the edge.
    assign prediction = pht[pred_idx][1];

    // Saturating increment/decrement of the counter being trained.
    always_comb begin
        upd_next = upd_cur;
        if (actual_taken) begin
            if (upd_cur != 2'b11) begin
                upd_next = upd_cur + 2'd1;
            end
        end else begin
            if (upd_cur != 2'b00) begin
                upd_next = upd_cur - 2'd1;
            end
        end
    end

    // Table storage: reset forces every entry to weakly not-taken.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(Depth); i++) begin
                pht[i] <= 2'b01;
            end
        end else if (update_en) begin
            pht[upd_idx] <= upd_next;
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios followed by
// randomized traffic checked against an array-of-integers reference model.
module tb_branch_predictor;

    localparam int unsigned K     = 13;
    localparam int          Depth = 1 << K;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_in;
    logic        update_en;
    logic [31:0] update_pc;
    logic        actual_taken;
    logic        prediction;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model: each entry is a confidence level 0..3.
    int ref_pht [Depth];

    branch_predictor #(
        .K(K)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pc_in       (pc_in),
        .update_en   (update_en),
        .update_pc   (update_pc),
        .actual_taken(actual_taken),
        .prediction  (prediction)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int idx_of(input logic [31:0] pc);
        return int'(pc[K+1:2]);
    endfunction

    function automatic logic ref_pred(input logic [31:0] pc);
        return ref_pht[idx_of(pc)] >= 2;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < Depth; i++) ref_pht[i] = 1;
    endtask

    task automatic model_update(input logic [31:0] pc, input logic taken);
        int i;
        i = idx_of(pc);
        if (taken) ref_pht[i] = (ref_pht[i] == 3) ? 3 : ref_pht[i] + 1;
        else       ref_pht[i] = (ref_pht[i] == 0) ? 0 : ref_pht[i] - 1;
    endtask

    function automatic logic [31:0] dut_entry(input int i);
        return {30'd0, dut.pht[i]};
    endfunction

    // One cycle: drive, check the pre-edge prediction, clock, update model.
    task automatic cycle(input logic [31:0] pc, input logic en, input logic [31:0] upc,
                         input logic taken);
        pc_in        = pc;
        update_en    = en;
        update_pc    = upc;
        actual_taken = taken;
        #1;
        check("pred_pre_edge", {31'd0, prediction}, {31'd0, ref_pred(pc)});
        @(posedge clk);
        if (en && rst) model_update(upc, taken);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b0;
        update_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
    endtask

    logic [1:0] seq_state [6] = '{2'd2, 2'd3, 2'd2, 2'd3, 2'd3, 2'd2};
    logic       seq_pred  [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic       seq_dir   [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    initial begin
        logic [31:0] pc, upc, alias_pc;
        logic        en, t;

        pc_in        = 32'h0;
        update_pc    = 32'h0;
        actual_taken = 1'b0;
        do_reset();

        // Reset state and simple taken training with saturation.
        pc_in = 32'h100;
        #1;
        check("reset_pred_100", {31'd0, prediction}, 32'd0);
        check("reset_pht_40", dut_entry('h40), 32'd1);
        check("reset_pht_1fff", dut_entry(Depth - 1), 32'd1);

        // Same-index update: old value before the edge, new value after.
        update_en = 1'b1; update_pc = 32'h100; actual_taken = 1'b1;
        #1;
        check("nobypass_pre", {31'd0, prediction}, 32'd0);
        @(posedge clk); model_update(32'h100, 1'b1); #1;
        check("nobypass_post", {31'd0, prediction}, 32'd1);
        check("pht_40_first", dut_entry('h40), 32'd2);
        cycle(32'h100, 1'b1, 32'h100, 1'b1);
        cycle(32'h100, 1'b1, 32'h100, 1'b1);
        check("pht_40_sat", dut_entry('h40), 32'd3);
        cycle(32'h100, 1'b1, 32'h100, 1'b1);
        check("pht_40_sat_hold", dut_entry('h40), 32'd3);

        // Not-taken saturation at 00.
        cycle(32'h200, 1'b1, 32'h200, 1'b0);
        check("pht_80_dec", dut_entry('h80), 32'd0);
        cycle(32'h200, 1'b1, 32'h200, 1'b0);
        check("pht_80_floor", dut_entry('h80), 32'd0);
        pc_in = 32'h200; #1;
        check("pred_200", {31'd0, prediction}, 32'd0);

        // T,T,N,T,T,N walk on 0x304.
        for (int s = 0; s < 6; s++) begin
            pc_in = 32'h304; update_en = 1'b1; update_pc = 32'h304; actual_taken = seq_dir[s];
            #1;
            check($sformatf("seq_pred_%0d", s), {31'd0, prediction}, {31'd0, seq_pred[s]});
            @(posedge clk); model_update(32'h304, seq_dir[s]); #1;
            check($sformatf("seq_state_%0d", s), dut_entry('hC1), {30'd0, seq_state[s]});
        end

        // Isolation of neighbours and aliasing above bit K+1.
        cycle(32'h100, 1'b1, 32'h103, 1'b1);
        check("iso_pht_80", dut_entry('h80), 32'd0);
        check("iso_pht_c1", dut_entry('hC1), 32'd2);
        alias_pc = 32'h100 + (32'd1 << (K + 2));
        pc_in = alias_pc; #1;
        check("alias_pred", {31'd0, prediction}, 32'd1);
        cycle(alias_pc, 1'b1, alias_pc, 1'b0);
        check("alias_pht_40", dut_entry('h40), 32'd2);

        // Disabled update with garbage operands changes nothing.
        cycle(32'h100, 1'b0, 32'h100, 1'b0);
        check("noupd_pht_40", dut_entry('h40), 32'd2);

        // Asynchronous reset between edges; updates ignored while held.
        cycle(32'h100, 1'b1, 32'h100, 1'b1);
        check("pretrain_pht_40", dut_entry('h40), 32'd3);
        pc_in = 32'h100;
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_pht_40", dut_entry('h40), 32'd1);
        check("async_rst_pred", {31'd0, prediction}, 32'd0);
        check("async_rst_pht_c1", dut_entry('hC1), 32'd1);
        model_reset();
        update_en = 1'b1; update_pc = 32'h100; actual_taken = 1'b1;
        @(posedge clk); #1;
        check("rst_held_ignore", dut_entry('h40), 32'd1);
        rst = 1'b1;
        cycle(32'h100, 1'b1, 32'h100, 1'b1);
        check("resume_pht_40", dut_entry('h40), 32'd2);

        // Randomized traffic concentrated on a few indices with random
        // high and low PC bits so aliasing and saturation occur often.
        for (int n = 0; n < 3000; n++) begin
            pc  = {$urandom} & ~(32'((1 << (K + 2)) - 1));
            pc  = pc | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
            upc = {$urandom} & ~(32'((1 << (K + 2)) - 1));
            upc = upc | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
            en  = ($urandom_range(0, 3) != 0);
            t   = $urandom_range(0, 1) != 0;
            cycle(pc, en, upc, t);
            check("rand_pht", dut_entry(idx_of(upc)), 32'(ref_pht[idx_of(upc)]));
        end

        // Whole-table sweep against the model.
        for (int i = 0; i < Depth; i++) begin
            if (dut_entry(i) !== 32'(ref_pht[i])) begin
                check($sformatf("sweep_pht_%0h", i), dut_entry(i), 32'(ref_pht[i]));
            end
        end
        check("sweep_pht_0", dut_entry(0), 32'(ref_pht[0]));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
